foc_top: RTL and testbench

//  Field-oriented current controller for a 3-phase motor; the top of the motor-control datapath.
//  Per accepted sample it runs Clarke, Park, two PI loops (d, q), inverse Park and inverse Clarke.
//  It then converts the three phase voltages into PWM duties.
//  A free-running carrier turns the duties into three PWM outputs.

---
 rtl/foc_pkg.sv | 89 ++++++++
 rtl/foc_pi.sv | 44 ++++
 rtl/foc_top.sv | 203 ++++++++++++++++++++
 tb/tb_foc_top.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/foc_pkg.sv
// Shared types, fixed-point constants, sine table and saturating arithmetic for the FOC datapath.
package foc_pkg;

    localparam int unsigned D_WIDTH = 19;
    localparam int unsigned Q_BITS  = 15;
    localparam int unsigned W_WIDTH = 2 * D_WIDTH + 1;

    typedef logic signed [D_WIDTH-1:0] word_t;
    typedef logic signed [W_WIDTH-1:0] wide_t;
    typedef logic        [D_WIDTH-1:0] uword_t;

    typedef enum logic [2:0] {
        S_IDLE, S_CLARKE, S_PARK, S_PI, S_IPARK, S_ICLARKE, S_ZSEQ, S_DUTY
    } state_e;

    localparam longint WORD_MAX  = (longint'(1) <<< (D_WIDTH - 1)) - 1;
    localparam longint Q_MAX     = (longint'(1) <<< Q_BITS) - 1;
    localparam word_t  ONE       = word_t'(longint'(1) <<< Q_BITS);
    localparam word_t  INV_SQRT3 = word_t'((longint'(18919) <<< Q_BITS) >>> 15);
    localparam word_t  SQRT3_2   = word_t'((longint'(28378) <<< Q_BITS) >>> 15);

    // sin(pi/2 * k/64) in Q15 for k = 0..63
    localparam logic [15:0] SIN_LUT [64] = '{
        16'd0,     16'd804,   16'd1608,  16'd2411,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
        16'd6393,  16'd7180,  16'd7962,  16'd8740,  16'd9512,  16'd10279, 16'd11039, 16'd11793,
        16'd12540, 16'd13279, 16'd14010, 16'd14733, 16'd15447, 16'd16151, 16'd16846, 16'd17531,
        16'd18205, 16'd18868, 16'd19520, 16'd20160, 16'd20788, 16'd21403, 16'd22006, 16'd22595,
        16'd23170, 16'd23732, 16'd24279, 16'd24812, 16'd25330, 16'd25833, 16'd26320, 16'd26791,
        16'd27246, 16'd27684, 16'd28106, 16'd28511, 16'd28899, 16'd29269, 16'd29622, 16'd29957,
        16'd30274, 16'd30572, 16'd30853, 16'd31114, 16'd31357, 16'd31581, 16'd31786, 16'd31972,
        16'd32138, 16'd32286, 16'd32413, 16'd32522, 16'd32610, 16'd32679, 16'd32729, 16'd32758
    };

    function automatic word_t sat(input wide_t x);
        word_t r;
        if (x > wide_t'(WORD_MAX))       r = word_t'(WORD_MAX);
        else if (x < -wide_t'(WORD_MAX)) r = word_t'(-WORD_MAX);
        else                             r = word_t'(x);
        return r;
    endfunction

    function automatic word_t add_s(input word_t a, input word_t b);
        return sat(wide_t'(a) + wide_t'(b));
    endfunction

    function automatic word_t sub_s(input word_t a, input word_t b);
        return sat(wide_t'(a) - wide_t'(b));
    endfunction

    function automatic word_t mul_s(input word_t a, input word_t b);
        wide_t p;
        p = wide_t'(a) * wide_t'(b);
        return sat(p >>> Q_BITS);
    endfunction

    function automatic word_t clamp_q(input word_t x);
        word_t r;
        if (x > word_t'(Q_MAX))       r = word_t'(Q_MAX);
        else if (x < -word_t'(Q_MAX)) r = word_t'(-Q_MAX);
        else                          r = x;
        return r;
    endfunction

    // ph: 8-bit phase, top two bits select the quadrant
    function automatic word_t sin_lut(input logic [7:0] ph);
        logic [5:0] k;
        word_t      mag;
        k = ph[5:0];
        if (!ph[6])      mag = word_t'((wide_t'(SIN_LUT[k]) <<< Q_BITS) >>> 15);
        else if (k == '0) mag = ONE;
        else             mag = word_t'((wide_t'(SIN_LUT[6'(7'd64 - {1'b0, k})]) <<< Q_BITS) >>> 15);
        return ph[7] ? -mag : mag;
    endfunction

    function automatic uword_t duty_of(input word_t v, input uword_t per);
        logic signed [D_WIDTH+1:0] biased;
        logic [2*D_WIDTH+1:0]      prod;
        logic [2*D_WIDTH+1:0]      scaled;
        uword_t                    r;
        biased = (D_WIDTH+2)'(v) + (D_WIDTH+2)'(ONE);
        prod   = (2*D_WIDTH+2)'($unsigned(biased)) * (2*D_WIDTH+2)'(per);
        scaled = prod >> (Q_BITS + 1);
        if (biased[D_WIDTH+1])                   r = '0;
        else if (scaled > (2*D_WIDTH+2)'(per))   r = per;
        else                                     r = uword_t'(scaled);
        return r;
    endfunction

endpackage

// File: rtl/foc_pi.sv
// One PI current loop: Kp/Ki gain registers with write decode, clamped integrator and output.
module foc_pi
    import foc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      wen_i,
    input  logic        [D_WIDTH-1:0] addr_i,
    input  logic signed [D_WIDTH-1:0] data_i,
    input  logic                      run_i,
    input  logic signed [D_WIDTH-1:0] ref_i,
    input  logic signed [D_WIDTH-1:0] meas_i,
    output logic signed [D_WIDTH-1:0] out_o
);

    word_t kp_q, ki_q, integ_q, out_q;
    word_t err, integ_d, out_d;

    // Output uses the freshly updated integrator
    always_comb begin
        err     = sub_s(ref_i, meas_i);
        integ_d = clamp_q(add_s(integ_q, mul_s(ki_q, err)));
        out_d   = clamp_q(add_s(mul_s(kp_q, err), integ_d));
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            kp_q    <= '0;
            ki_q    <= '0;
            integ_q <= '0;
            out_q   <= '0;
        end else begin
            if (wen_i && (addr_i == D_WIDTH'(0))) kp_q <= data_i;
            if (wen_i && (addr_i == D_WIDTH'(1))) ki_q <= data_i;
            if (run_i) begin
                integ_q <= integ_d;
                out_q   <= out_d;
            end
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/foc_top.sv
// FOC current controller: sample FSM, Clarke/Park, d/q PI, inverse transforms, duties, PWM carrier.
// Define FOC_SVM_EN to add min/max zero-sequence injection (one extra cycle per sample).
module foc_top
    import foc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      valid,
    output logic                      ready,
    input  logic        [D_WIDTH-1:0] angle_in,
    input  logic signed [D_WIDTH-1:0] currA_in,
    input  logic signed [D_WIDTH-1:0] currB_in,
    input  logic signed [D_WIDTH-1:0] currC_in,
    input  logic signed [D_WIDTH-1:0] currT_in,
    input  logic        [D_WIDTH-1:0] periodTop,
    output logic                      pwmA_out,
    output logic                      pwmB_out,
    output logic                      pwmC_out,
    input  logic                      pid_d_wen,
    input  logic                      pid_q_wen,
    input  logic        [D_WIDTH-1:0] pid_d_addr,
    input  logic        [D_WIDTH-1:0] pid_q_addr,
    input  logic signed [D_WIDTH-1:0] pid_d_data,
    input  logic signed [D_WIDTH-1:0] pid_q_data
);

    state_e     state_q;
    logic       ready_q;
    logic [7:0] ang_q;
    word_t      a_q, b_q, t_q;
    uword_t     per_lat_q;
    word_t      al_q, be_q, d_q, q_q;
    word_t      va_q, vb_q, vc_q;
    uword_t     sh_a_q, sh_b_q, sh_c_q;
    word_t      sin_w, cos_w, vd, vq;
    logic       pi_run;

    // Phase C current is implied by A and B; low angle bits are below LUT resolution
    logic unused_in;
    assign unused_in = ^{currC_in, angle_in[D_WIDTH-9:0]};

    assign sin_w  = sin_lut(ang_q);
    assign cos_w  = sin_lut(ang_q + 8'd64);
    assign pi_run = (state_q == S_PI);

    foc_pi u_pi_d (
        .clk    (clk),
        .rstb   (rstb),
        .wen_i  (pid_d_wen),
        .addr_i (pid_d_addr),
        .data_i (pid_d_data),
        .run_i  (pi_run),
        .ref_i  (word_t'(0)),
        .meas_i (d_q),
        .out_o  (vd)
    );

    foc_pi u_pi_q (
        .clk    (clk),
        .rstb   (rstb),
        .wen_i  (pid_q_wen),
        .addr_i (pid_q_addr),
        .data_i (pid_q_data),
        .run_i  (pi_run),
        .ref_i  (t_q),
        .meas_i (q_q),
        .out_o  (vq)
    );

`ifdef FOC_SVM_EN
    word_t v_max, v_min, zoff;
    always_comb begin
        v_max = va_q;
        v_min = va_q;
        if (vb_q > v_max) v_max = vb_q;
        if (vc_q > v_max) v_max = vc_q;
        if (vb_q < v_min) v_min = vb_q;
        if (vc_q < v_min) v_min = vc_q;
        zoff = sub_s(word_t'(0), add_s(v_max, v_min) >>> 1);
    end
`endif

    // Sample sequencer: one transform stage per cycle
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            ang_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            t_q       <= '0;
            per_lat_q <= '0;
            al_q      <= '0;
            be_q      <= '0;
            d_q       <= '0;
            q_q       <= '0;
            va_q      <= '0;
            vb_q      <= '0;
            vc_q      <= '0;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            sh_c_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid && ready_q) begin
                        ang_q     <= angle_in[D_WIDTH-1 -: 8];
                        a_q       <= currA_in;
                        b_q       <= currB_in;
                        t_q       <= currT_in;
                        per_lat_q <= periodTop;
                        ready_q   <= 1'b0;
                        state_q   <= S_CLARKE;
                    end
                end
                S_CLARKE: begin
                    al_q    <= a_q;
                    be_q    <= mul_s(add_s(a_q, add_s(b_q, b_q)), INV_SQRT3);
                    state_q <= S_PARK;
                end
                S_PARK: begin
                    d_q     <= add_s(mul_s(al_q, cos_w), mul_s(be_q, sin_w));
                    q_q     <= sub_s(mul_s(be_q, cos_w), mul_s(al_q, sin_w));
                    state_q <= S_PI;
                end
                S_PI: state_q <= S_IPARK;
                S_IPARK: begin
                    al_q    <= sub_s(mul_s(vd, cos_w), mul_s(vq, sin_w));
                    be_q    <= add_s(mul_s(vd, sin_w), mul_s(vq, cos_w));
                    state_q <= S_ICLARKE;
                end
                S_ICLARKE: begin
                    va_q    <= al_q;
                    vb_q    <= add_s(sub_s(word_t'(0), al_q >>> 1), mul_s(SQRT3_2, be_q));
                    vc_q    <= sub_s(sub_s(word_t'(0), al_q >>> 1), mul_s(SQRT3_2, be_q));
`ifdef FOC_SVM_EN
                    state_q <= S_ZSEQ;
`else
                    state_q <= S_DUTY;
`endif
                end
`ifdef FOC_SVM_EN
                S_ZSEQ: begin
                    va_q    <= add_s(va_q, zoff);
                    vb_q    <= add_s(vb_q, zoff);
                    vc_q    <= add_s(vc_q, zoff);
                    state_q <= S_DUTY;
                end
`endif
                S_DUTY: begin
                    sh_a_q  <= duty_of(va_q, per_lat_q);
                    sh_b_q  <= duty_of(vb_q, per_lat_q);
                    sh_c_q  <= duty_of(vc_q, per_lat_q);
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready = ready_q;

    // PWM carrier; period and duties only change at the wrap
    uword_t cnt_q, cnt_d, per_q;
    uword_t act_a_q, act_b_q, act_c_q;
    logic   pwm_a_q, pwm_b_q, pwm_c_q;
    logic   wrap;

    always_comb begin
        wrap  = (per_q == '0) || (cnt_q == per_q - D_WIDTH'(1));
        cnt_d = wrap ? '0 : cnt_q + D_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            cnt_q   <= '0;
            per_q   <= '0;
            act_a_q <= '0;
            act_b_q <= '0;
            act_c_q <= '0;
            pwm_a_q <= 1'b0;
            pwm_b_q <= 1'b0;
            pwm_c_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pwm_a_q <= (per_q != '0) && (cnt_q < act_a_q);
            pwm_b_q <= (per_q != '0) && (cnt_q < act_b_q);
            pwm_c_q <= (per_q != '0) && (cnt_q < act_c_q);
            if (wrap) begin
                per_q   <= periodTop;
                act_a_q <= sh_a_q;
                act_b_q <= sh_b_q;
                act_c_q <= sh_c_q;
            end
        end
    end

    assign pwmA_out = pwm_a_q;
    assign pwmB_out = pwm_b_q;
    assign pwmC_out = pwm_c_q;

endmodule

// File: tb/tb_foc_top.sv
// Directed testbench for foc_top: duties are measured as PWM high counts over one carrier period.
module tb_foc_top;
    import foc_pkg::*;

    logic clk = 1'b0;
    logic rstb, valid, ready;
    logic [D_WIDTH-1:0] angle_in, periodTop, pid_d_addr, pid_q_addr;
    logic signed [D_WIDTH-1:0] currA_in, currB_in, currC_in, currT_in, pid_d_data, pid_q_data;
    logic pid_d_wen, pid_q_wen, pwmA_out, pwmB_out, pwmC_out;

    int n_checks = 0;
    int n_pass   = 0;
    int lat, ca, cb, cc;

    always #5 clk = ~clk;

    foc_top dut (
        .clk(clk), .rstb(rstb), .valid(valid), .ready(ready),
        .angle_in(angle_in), .currA_in(currA_in), .currB_in(currB_in),
        .currC_in(currC_in), .currT_in(currT_in), .periodTop(periodTop),
        .pwmA_out(pwmA_out), .pwmB_out(pwmB_out), .pwmC_out(pwmC_out),
        .pid_d_wen(pid_d_wen), .pid_q_wen(pid_q_wen),
        .pid_d_addr(pid_d_addr), .pid_q_addr(pid_q_addr),
        .pid_d_data(pid_d_data), .pid_q_data(pid_q_data)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
    endtask

    task automatic write_gain(input bit to_d, input bit to_q, input int addr, input int data);
        @(negedge clk);
        pid_d_addr = D_WIDTH'(addr);
        pid_q_addr = D_WIDTH'(addr);
        pid_d_data = D_WIDTH'(data);
        pid_q_data = D_WIDTH'(data);
        pid_d_wen  = to_d;
        pid_q_wen  = to_q;
        @(negedge clk);
        pid_d_wen  = 1'b0;
        pid_q_wen  = 1'b0;
    endtask

    // mode 1: valid pokes while busy, 2: Kp_q<=0 landing in the PI cycle, 3: reset mid-computation
    task automatic run_txn(input int ph, input int a, input int b, input int t, input int mode,
                           output int lat_o);
        int guard = 0;
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        angle_in = D_WIDTH'(ph) << (D_WIDTH - 8);
        currA_in = D_WIDTH'(a);
        currB_in = D_WIDTH'(b);
        currC_in = D_WIDTH'(-a - b);
        currT_in = D_WIDTH'(t);
        valid    = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        lat_o = 0;
        while (!ready && lat_o < 50) begin
            lat_o++;
            case (mode)
                1: begin valid = (lat_o < 4); currT_in = '0; end
                2: begin pid_q_addr = '0; pid_q_data = '0; pid_q_wen = (lat_o == 3); end
                3: rstb = (lat_o == 3);
                default: ;
            endcase
            @(negedge clk);
        end
        valid     = 1'b0;
        pid_q_wen = 1'b0;
        rstb      = 1'b0;
    endtask

    task automatic measure(input int win, output int a_o, output int b_o, output int c_o);
        repeat (1003) @(negedge clk);
        a_o = 0; b_o = 0; c_o = 0;
        repeat (win) begin
            @(negedge clk);
            a_o += int'(pwmA_out);
            b_o += int'(pwmB_out);
            c_o += int'(pwmC_out);
        end
    endtask

    task automatic expect_duty(input string tag, input int ea, input int eb, input int ec);
        measure(1000, ca, cb, cc);
        check({tag, " dutyA"}, ca, ea);
        check({tag, " dutyB"}, cb, eb);
        check({tag, " dutyC"}, cc, ec);
    endtask

    initial begin
        rstb = 1'b1; valid = 1'b0; periodTop = D_WIDTH'(1000);
        angle_in = '0; currA_in = '0; currB_in = '0; currC_in = '0; currT_in = '0;
        pid_d_wen = 1'b0; pid_q_wen = 1'b0; pid_d_addr = '0; pid_q_addr = '0;
        pid_d_data = '0; pid_q_data = '0;
        repeat (2) @(negedge clk);
        rstb = 1'b0;

        check("reset ready", ready, 1);
        check("reset pwmA", pwmA_out, 0);
        check("reset pwmB", pwmB_out, 0);
        check("reset pwmC", pwmC_out, 0);

        // unmapped gain address leaves Kp_q at 0
        write_gain(1'b0, 1'b1, 2, 32768);
        run_txn(0, 0, 0, 16384, 0, lat);
        check("addr2 latency", lat, 6);
        expect_duty("addr2", 500, 500, 500);

        write_gain(1'b0, 1'b1, 0, 32768);
        run_txn(0, 0, 0, 16384, 0, lat);
        check("kp latency", lat, 6);
        expect_duty("kp", 500, 716, 283);

        run_txn(0, 0, 0, 16384, 1, lat);
        check("busy latency", lat, 6);
        expect_duty("busy", 500, 716, 283);

        run_txn(0, 0, 0, 16384, 2, lat);
        check("pi-write latency", lat, 6);
        expect_duty("pi-write old", 500, 716, 283);
        run_txn(0, 0, 0, 16384, 0, lat);
        expect_duty("pi-write new", 500, 500, 500);

        do_reset();
        write_gain(1'b0, 1'b1, 1, 512);
        run_txn(0, 0, 0, 16384, 0, lat);
        expect_duty("integ1", 500, 503, 496);
        run_txn(0, 0, 0, 16384, 0, lat);
        expect_duty("integ2", 500, 506, 493);

        do_reset();
        write_gain(1'b0, 1'b1, 0, 131072);
        run_txn(0, 0, 0, 32764, 0, lat);
        expect_duty("sat", 500, 932, 67);

        do_reset();
        write_gain(1'b1, 1'b1, 0, 4096);
        run_txn(0, 16384, -16384, 0, 0, lat);
        expect_duty("park0", 468, 531, 500);
        run_txn(64, 16384, -16384, 0, 0, lat);
        expect_duty("park90", 468, 531, 500);

        do_reset();
        periodTop = '0;
        write_gain(1'b0, 1'b1, 0, 32768);
        run_txn(0, 0, 0, 16384, 0, lat);
        measure(200, ca, cb, cc);
        check("per0 pwmA", ca, 0);
        check("per0 pwmB", cb, 0);
        check("per0 pwmC", cc, 0);

        do_reset();
        periodTop = D_WIDTH'(1000);
        write_gain(1'b0, 1'b1, 0, 32768);
        run_txn(0, 0, 0, 16384, 3, lat);
        check("abort ready", lat, 3);
        expect_duty("abort", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
